// File: rtl/iob_fifo_wr_ctrl_pkg.sv
// rtl/iob_fifo_wr_ctrl_pkg.sv - shared async FIFO pointer helpers
// Pointer width derivation and gray-to-binary conversion, shared by both FIFO sides.
package iob_fifo_wr_ctrl_pkg;

  localparam int PTR_MAX_W  = 32;
  localparam int DEF_ADDR_W = 4;

  // One extra pointer bit distinguishes full from empty.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  // Operates at PTR_MAX_W; zero-extended gray values convert correctly at any
  // narrower width, so callers cast the argument up and the result back down.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/iob_fifo_wr_ctrl_sync.sv
// rtl/iob_fifo_wr_ctrl_sync.sv - two-stage clock-domain synchroniser
// Multi-bit input must be gray coded so at most one bit changes per transfer.
module iob_sync #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         cke_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] r_sync1;
  logic [W-1:0] r_sync2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else if (cke_i) begin
      r_sync1 <= d_i;
      r_sync2 <= r_sync1;
    end
  end

  assign q_o = r_sync2;

endmodule

// File: rtl/iob_fifo_wr_ctrl.sv
// rtl/iob_fifo_wr_ctrl.sv - async FIFO write-side pointer and flag controller
// Produces write address, level, full/almost-full, counter increment and sticky overflow.
module iob_fifo_wr_ctrl
  import iob_fifo_wr_ctrl_pkg::*;
#(
  parameter  int ADDR_W             = DEF_ADDR_W,
  parameter  int ALMOST_FULL_MARGIN = 1,
  localparam int W                  = ptr_w(ADDR_W)
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              w_en_i,
  input  logic [W-1:0]      w_gray_i,
  input  logic [W-1:0]      r_gray_i,
  output logic              w_inc_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [W-1:0]      level_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic              overflow_o
);

  localparam logic [W-1:0] AF_THRESH = W'((1 << ADDR_W) - ALMOST_FULL_MARGIN);

  logic [W-1:0] w_r_sync;
  logic [W-1:0] w_w_bin;
  logic [W-1:0] w_r_bin;
  logic [W-1:0] w_level;
  logic         w_full;
  logic         r_overflow;

  iob_sync #(
    .W(W)
  ) u_r_sync (
    .clk_i (clk_i),
    .cke_i (cke_i),
    .rst_i (rst_i),
    .d_i   (r_gray_i),
    .q_o   (w_r_sync)
  );

  assign w_w_bin = W'(gray2bin(PTR_MAX_W'(w_gray_i)));
  assign w_r_bin = W'(gray2bin(PTR_MAX_W'(w_r_sync)));

  // Unsigned modular difference handles pointer wrap without a signed compare.
  assign w_level = w_w_bin - w_r_bin;

  // Full when the write pointer is exactly one lap ahead: top two gray bits inverted.
  generate
    if (W == 2) begin : g_full_w2
      assign w_full = (w_gray_i == ~w_r_sync);
    end else begin : g_full_wn
      assign w_full = (w_gray_i == {~w_r_sync[W-1:W-2], w_r_sync[W-3:0]});
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_overflow <= 1'b0;
    end else if (cke_i && w_en_i && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  // Combinational so the gray counter and the RAM act on the same edge.
  assign w_inc_o       = w_en_i & ~w_full & cke_i & ~rst_i;
  assign w_addr_o      = w_w_bin[ADDR_W-1:0];
  assign level_o       = w_level;
  assign full_o        = w_full;
  assign almost_full_o = (w_level >= AF_THRESH);
  assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_iob_fifo_wr_ctrl.sv
// tb/tb_iob_fifo_wr_ctrl.sv - directed scoreboard bench for iob_fifo_wr_ctrl
module tb_iob_fifo_wr_ctrl;

  localparam int ADDR_W = 2;
  localparam int W      = 3;

  logic              clk = 1'b0;
  logic              cke_i;
  logic              rst_i;
  logic              w_en_i;
  logic [W-1:0]      w_gray_i;
  logic [W-1:0]      r_gray_i;
  logic              w_inc_o;
  logic [ADDR_W-1:0] w_addr_o;
  logic [W-1:0]      level_o;
  logic              full_o;
  logic              almost_full_o;
  logic              overflow_o;

  logic              use_cnt;
  logic [W-1:0]      w_gray_drv;
  logic [W-1:0]      cnt = '0;

  typedef struct {
    string             tag;
    logic [W-1:0]      level;
    logic              full;
    logic              af;
    logic              ovf;
    logic              inc;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  int                n_checks = 0;
  int                n_errors = 0;
  int                pulses;
  logic [W-1:0]      r_seq [3];

  iob_fifo_wr_ctrl #(
    .ADDR_W             (ADDR_W),
    .ALMOST_FULL_MARGIN (1)
  ) dut (
    .clk_i         (clk),
    .cke_i         (cke_i),
    .rst_i         (rst_i),
    .w_en_i        (w_en_i),
    .w_gray_i      (w_gray_i),
    .r_gray_i      (r_gray_i),
    .w_inc_o       (w_inc_o),
    .w_addr_o      (w_addr_o),
    .level_o       (level_o),
    .full_o        (full_o),
    .almost_full_o (almost_full_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  // Reference write-side gray counter sharing reset and clock enable.
  always @(posedge clk) begin
    if (rst_i) cnt <= '0;
    else if (cke_i && w_inc_o) cnt <= cnt + 1'b1;
  end

  assign w_gray_i = use_cnt ? (cnt ^ (cnt >> 1)) : w_gray_drv;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [W-1:0] lv, input logic f,
                          input logic af, input logic ov, input logic inc,
                          input logic [ADDR_W-1:0] ad);
    exp_t e;
    e.tag = tag; e.level = lv; e.full = f; e.af = af; e.ovf = ov; e.inc = inc; e.addr = ad;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard.empty", 8'd0, 8'd1);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, ".level"}, 8'(level_o),       8'(e.level));
      chk({e.tag, ".full"},  8'(full_o),        8'(e.full));
      chk({e.tag, ".af"},    8'(almost_full_o), 8'(e.af));
      chk({e.tag, ".ovf"},   8'(overflow_o),    8'(e.ovf));
      chk({e.tag, ".inc"},   8'(w_inc_o),       8'(e.inc));
      chk({e.tag, ".addr"},  8'(w_addr_o),      8'(e.addr));
    end
  endtask

  task automatic point(input string tag, input logic [W-1:0] lv, input logic f,
                       input logic af, input logic ov, input logic inc,
                       input logic [ADDR_W-1:0] ad);
    push_exp(tag, lv, f, af, ov, inc, ad);
    #1;
    pop_check();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a non-zero remote pointer and a write request pending.
    cke_i = 1'b1; rst_i = 1'b1; w_en_i = 1'b1; r_gray_i = 3'b101;
    use_cnt = 1'b1; w_gray_drv = '0;
    #1;
    chk("reset.inc_gated", 8'(w_inc_o), 8'd0);
    step(2);
    point("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    rst_i = 1'b0; w_en_i = 1'b0; r_gray_i = 3'b000;
    step(2);

    // Synchroniser latency: w bin 3, read pointer moves 0 -> 1.
    use_cnt = 1'b0; w_gray_drv = 3'b010;
    point("sync.before", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
    r_gray_i = 3'b001;
    step(1);
    point("sync.edge1", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
    step(1);
    point("sync.edge2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);

    // Full and sticky overflow.
    r_gray_i = 3'b000;
    step(2);
    w_gray_drv = 3'b110;
    point("full.static", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    w_en_i = 1'b1;
    point("full.wen", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1);
    w_en_i = 1'b0;
    point("full.ovf_set", 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    step(1);
    point("full.ovf_sticky", 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);

    rst_i = 1'b1; w_gray_drv = 3'b000;
    step(1);
    rst_i = 1'b0;

    // Pointer wrap: write pointer numerically below read pointer.
    r_gray_i = 3'b101;
    step(2);
    point("wrap.a", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    w_gray_drv = 3'b011; r_gray_i = 3'b100;
    step(2);
    point("wrap.b", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);

    // Write stream with the reference gray counter attached.
    use_cnt = 1'b1; rst_i = 1'b1; r_gray_i = 3'b000;
    step(1);
    rst_i = 1'b0; w_en_i = 1'b1;
    for (int a = 0; a < 4; a++) addr_q.push_back(ADDR_W'(a));
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (w_inc_o) begin
        pulses++;
        if (addr_q.size() > 0) chk("stream.addr", 8'(w_addr_o), 8'(addr_q.pop_front()));
        else chk("stream.extra_pulse", 8'd1, 8'd0);
      end
      step(1);
    end
    w_en_i = 1'b0;
    chk("stream.pulses", 8'(pulses), 8'd4);
    chk("stream.addr_q_left", 8'(addr_q.size()), 8'd0);
    point("stream.end", 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);

    // Clock enable low freezes synchroniser and overflow.
    use_cnt = 1'b0; w_gray_drv = 3'b000; rst_i = 1'b1;
    step(1);
    rst_i = 1'b0; w_gray_drv = 3'b110; r_gray_i = 3'b000;
    step(1);
    point("cke.full", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    r_seq[0] = 3'b011; r_seq[1] = 3'b010; r_seq[2] = 3'b111;
    cke_i = 1'b0; w_en_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      r_gray_i = r_seq[k];
      #1;
      chk("cke.hold.inc", 8'(w_inc_o), 8'd0);
      step(1);
    end
    point("cke.after", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    cke_i = 1'b1; r_gray_i = 3'b011;
    point("cke.resume", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1);
    w_en_i = 1'b0;
    point("cke.ovf", 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    step(1);
    point("cke.sync", 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
